// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode constants, fetch FSM encoding and branch offset helper.
// No logic of its own; imported by the fetch unit and its next-PC block.
// Encodings must match the controller's decoder.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  // IR contents after reset: opcode field all ones, everything else zero
  localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_t;

  // Word-aligned branch displacement: sign-extended imm16 scaled by 4
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory, issue and branch-resolution signals.
// master = fetch unit side, slave = memory/controller side.
// Pure wiring, no latency.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        ir_valid;
  logic        ir_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Beq;
  logic        Bne;
  logic        J;
  logic        JR;
  logic        Z;
  logic [31:0] jr_target;
  logic        taken;
  logic [31:0] retired;
  logic        fault;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ack,
    input  stall,
    output ir_valid, input ir_ready,
    output opcode, funct, rs, rt, rd, shamt, imm16, pc, pc_plus4,
    input  Beq, Bne, J, JR, Z, jr_target,
    output taken, retired, fault
  );

  modport slave (
    input  imem_req, imem_addr, output imem_rdata, imem_ack,
    output stall,
    input  ir_valid, output ir_ready,
    input  opcode, funct, rs, rt, rd, shamt, imm16, pc, pc_plus4,
    output Beq, Bne, J, JR, Z, jr_target,
    input  taken, retired, fault
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection from the controller's branch/jump decisions.
// Purely combinational, zero latency.
// No handshake; consumed only while the fetch FSM is resolving.
module ifu_next_pc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] ir,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        J,
  input  logic        JR,
  input  logic        Z,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        misalign
);

  // Opcode bits are decoded by the controller, which hands us the decisions
  logic [5:0] unused_opcode;
  assign unused_opcode = ir[31:26];

  // Priority JR > J > conditional branch > sequential
  always_comb begin
    next_pc  = pc_plus4;
    taken    = 1'b0;
    misalign = 1'b0;
    if (JR) begin
      next_pc  = jr_target;
      taken    = 1'b1;
      misalign = |jr_target[1:0];
    end else if (J) begin
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      taken   = 1'b1;
    end else if ((Beq && Z) || (Bne && !Z)) begin
      next_pc = pc_plus4 + branch_offset(ir[15:0]);
      taken   = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner: fetches words over req/ack, issues fields over valid/ready, resolves next PC.
// Latency: FETCH->ISSUE->RESOLVE, one instruction per 3 cycles with zero-wait memory.
// Backpressure: stall blocks fetch launch and issue; ir_ready low holds ISSUE; a launched request is held until ack.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic [31:0]  retired_q;
  logic [7:0]   wait_cnt;
  logic         req_out;
  logic         live;
  logic         ir_valid_q;
  logic         taken_q;
  logic         fault_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         br_taken;
  logic         misalign;
  logic         req;
  logic         accept;

  assign pc_plus4 = pc_q + 32'd4;

  // live keeps the request low until the first edge after reset release;
  // once a request is out, stall can no longer withdraw it
  assign req    = live && (state == ST_FETCH) && (!bus.stall || req_out);
  assign accept = ir_valid_q && bus.ir_ready && !bus.stall;

  ifu_next_pc u_next_pc (
    .pc_plus4  (pc_plus4),
    .ir        (ir_q),
    .Beq       (bus.Beq),
    .Bne       (bus.Bne),
    .J         (bus.J),
    .JR        (bus.JR),
    .Z         (bus.Z),
    .jr_target (bus.jr_target),
    .next_pc   (next_pc),
    .taken     (br_taken),
    .misalign  (misalign)
  );

  // Fetch/issue/resolve sequencing, PC/IR ownership and sticky fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_WORD;
      retired_q  <= 32'd0;
      wait_cnt   <= 8'd0;
      req_out    <= 1'b0;
      live       <= 1'b0;
      ir_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      live    <= 1'b1;
      taken_q <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (req) begin
            if (bus.imem_ack) begin
              ir_q       <= bus.imem_rdata;
              req_out    <= 1'b0;
              ir_valid_q <= 1'b1;
              wait_cnt   <= 8'd0;
              state      <= ST_ISSUE;
            end else if (wait_cnt == WAIT_LAST) begin
              req_out <= 1'b0;
              fault_q <= 1'b1;
              state   <= ST_FAULT;
            end else begin
              req_out  <= 1'b1;
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            ir_valid_q <= 1'b0;
            retired_q  <= retired_q + 32'd1;
            state      <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (misalign) begin
            fault_q <= 1'b1;
            state   <= ST_FAULT;
          end else begin
            pc_q    <= next_pc;
            taken_q <= br_taken;
            state   <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.opcode    = ir_q[31:26];
  assign bus.rs        = ir_q[25:21];
  assign bus.rt        = ir_q[20:16];
  assign bus.rd        = ir_q[15:11];
  assign bus.shamt     = ir_q[10:6];
  assign bus.funct     = ir_q[5:0];
  assign bus.imm16     = ir_q[15:0];
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.taken     = taken_q;
  assign bus.retired   = retired_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side counterpart of the opcode/funct control FSM. Owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents decoded instruction fields to the controller over a valid/ready handshake. It then takes the controller's Beq/Bne/J/JR decisions and the ALU Z flag back to compute the next PC. Sits between instruction memory and the control FSM / register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 255, max cycles imem_req may stay high without imem_ack before fault (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held until ack
imem_addr  out  32  fetch address (= pc), stable while imem_req high
imem_rdata  in  32  instruction word, valid when imem_ack high
imem_ack  in  1  fetch complete; sampled every cycle imem_req is high, including the first
stall  in  1  blocks launch of a new fetch and blocks issue
ir_valid  out  1  instruction fields valid to controller
ir_ready  in  1  controller accepts instruction
opcode  out  6  ir[31:26]
funct  out  6  ir[5:0]
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
shamt  out  5  ir[10:6]
imm16  out  16  ir[15:0]
pc  out  32  address of instruction in IR
pc_plus4  out  32  pc+4 (link value for JAL)
Beq, Bne, J, JR  in  1 each  controller branch/jump decisions, sampled in RESOLVE only
Z  in  1  ALU zero flag, sampled in RESOLVE only
jr_target  in  32  register value for JR
taken  out  1  one-cycle pulse when a non-sequential PC is loaded
retired  out  32  count of instructions accepted by the controller; wraps modulo 2^32
fault  out  1  sticky error flag

Behaviour:
- Reset (rst low, async): pc=RESET_PC; ir=32'hFC00_0000 (NOP, opcode 6'b111111); state=FETCH; imem_req=0; ir_valid=0; taken=0; retired=0; fault=0; wait counter=0. Deassertion is taken synchronously on the next clk edge.
- States: FETCH, ISSUE, RESOLVE, FAULT.
- FETCH:
  - imem_req=1 whenever the state is FETCH and (stall=0 or a request is already outstanding).
  - Once raised, imem_req is never dropped by stall.
  - Ack sampled high: ir<=imem_rdata, imem_req<=0, ir_valid<=1, wait counter cleared, go to ISSUE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT: imem_req<=0, fault<=1, go to FAULT.
- ISSUE:
  - ir_valid=1; all fields held stable.
  - Acceptance = ir_valid & ir_ready & ~stall. On acceptance: ir_valid<=0, retired<=retired+1, go to RESOLVE.
- RESOLVE (exactly one cycle). Next PC, in priority order:
  - JR: jr_target. If jr_target[1:0]!=0: fault<=1, go to FAULT, pc unchanged.
  - J: {pc_plus4[31:28], ir[25:0], 2'b00}.
  - Beq & Z, or Bne & ~Z: pc_plus4 + (sign_extend(imm16) << 2), computed modulo 2^32.
  - Otherwise: pc_plus4.
  - taken=1 for one cycle if any of the first three cases loads pc. Then go to FETCH.
- Throughput: with zero-wait memory (ack in the first req cycle) and ready high, one instruction every 3 cycles.
- FAULT: absorbing until reset. imem_req=0, ir_valid=0, pc and ir frozen, fault=1.
- Ack seen while in ISSUE or RESOLVE (no request outstanding): ignored.
- pc_plus4 wraps at 32'hFFFF_FFFC to 0.

Decomposition:
- Shared package:
  - opcode constants: OP_RTYPE 6'b000000, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_J 6'b000010, OP_JAL 6'b000011, OP_NOP 6'b111111
  - NOP_WORD 32'hFC00_0000
  - fetch state encoding
- One combinational sub-module, ifu_next_pc: inputs pc_plus4, ir, Beq, Bne, J, JR, Z, jr_target; outputs next_pc, taken, misalign.

Test Plan:
- Reset mid-fetch: assert rst while imem_req=1 and ack is pending -> imem_req=0, pc=0, ir=32'hFC00_0000, fault=0, retired=0 immediately; first fetch at address 0 after release.
- Sequential flow, zero-wait memory, ir_ready=1: words at 0x0/0x4/0x8 -> imem_addr sequence 0,4,8; ir_valid high every 3rd cycle; retired=3.
- Branch taken: BEQ at 0x10 with imm16=16'hFFFC, Beq=1, Z=1 -> next imem_addr=0x04, taken pulse. Same stimulus with Z=0 -> imem_addr=0x14, no taken pulse.
- Jump and JR: J with ir[25:0]=26'h0000040 at pc=0x20 -> imem_addr=0x100. JR with jr_target=0x200 -> 0x200. JR with jr_target=0x202 -> fault=1 and FAULT state; no further imem_req.
- Handshake stress: ack delayed 5 cycles, stall toggled during the wait, and ir_ready held low 4 cycles -> imem_req and imem_addr stay stable; fields stay stable in ISSUE; retired increments once.
- Timeout: MAX_WAIT=8, ack never asserted -> fault=1 on the 8th req cycle; imem_req drops; state remains FAULT until rst.
